mic1_mem_ctrl: RTL and testbench

- Memory-port sequencer for the MIC-1 datapath. Accepts the per-microinstruction memory command (WRITE/READ/FETCH) with the current MAR, MDR and PC values.
- Serialises those operations onto the single word-wide main-memory bus using a valid/ready handshake.
- Returns loaded words to MDR and fetched bytes to MBR.
- Drives cmd_ready/busy so the microsequencer stalls while memory is outstanding.

---
 rtl/mic1_mem_ctrl.sv | 119 +++++++++++
 tb/tb_mic1_mem_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mic1_mem_ctrl.sv
// mic1_mem_ctrl: serialises MIC-1 WRITE/READ/FETCH commands onto a valid/ready word bus
// Ports: clk, resetn (sync, active-low); cmd_valid/cmd_wr/cmd_rd/cmd_fetch + mar/mdr_in/pc command side
// with cmd_ready/busy stall; mdr_load/mdr_data and mbr_load/mbr_data results; mem_valid/mem_addr/
// mem_wdata/mem_wstrb/mem_ready/mem_rdata bus; bus_err (timeout abort) and cmd_err (wr & rd) pulses.
module mic1_mem_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  input  logic        cmd_wr,
  input  logic        cmd_rd,
  input  logic        cmd_fetch,
  output logic        cmd_ready,
  input  logic [31:0] mar,
  input  logic [31:0] mdr_in,
  input  logic [31:0] pc,
  output logic        mdr_load,
  output logic [31:0] mdr_data,
  output logic        mbr_load,
  output logic [7:0]  mbr_data,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        bus_err,
  output logic        cmd_err
);
  typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;
  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);
  state_t state, state_d;
  logic pend_rd, pend_fetch;
  logic [31:0] pc_q;
  logic [15:0] cnt;
  logic accept, legal, done, expire;
  assign cmd_ready = state == IDLE;
  assign busy = !cmd_ready;
  assign accept = cmd_valid & cmd_ready;
  assign legal = cmd_wr ^ cmd_rd;
  assign done = mem_valid & mem_ready;
  assign expire = mem_valid & !mem_ready & (cnt == LIMIT);
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = !accept ? IDLE : legal ? DATA : cmd_fetch ? FETCH : IDLE;
      DATA:    state_d = expire ? IDLE : done ? (pend_fetch ? FETCH : IDLE) : DATA;
      FETCH:   state_d = (expire | done) ? IDLE : FETCH;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      pend_rd    <= 1'b0;
      pend_fetch <= 1'b0;
      pc_q       <= '0;
      cnt        <= '0;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      mdr_load   <= 1'b0;
      mdr_data   <= '0;
      mbr_load   <= 1'b0;
      mbr_data   <= '0;
      bus_err    <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      state    <= state_d;
      mdr_load <= 1'b0;
      mbr_load <= 1'b0;
      bus_err  <= expire;
      cmd_err  <= accept & cmd_wr & cmd_rd;
      if (accept) begin
        pend_rd    <= cmd_rd & !cmd_wr;
        pend_fetch <= cmd_fetch;
        pc_q       <= pc;
      end else if (state_d == IDLE) begin
        pend_rd    <= 1'b0;
        pend_fetch <= 1'b0;
      end
      // A fetch queued behind a data op raises mem_valid one cycle after the data op drops it.
      if (accept & legal) begin
        mem_valid <= 1'b1;
        mem_addr  <= {mar[29:0], 2'b00};
        mem_wdata <= cmd_wr ? mdr_in : '0;
        mem_wstrb <= cmd_wr ? 4'hF : 4'h0;
        cnt       <= '0;
      end else if (accept & cmd_fetch) begin
        mem_valid <= 1'b1;
        mem_addr  <= {pc[31:2], 2'b00};
        mem_wdata <= '0;
        mem_wstrb <= 4'h0;
        cnt       <= '0;
      end else if (state == FETCH && !mem_valid) begin
        mem_valid <= 1'b1;
        mem_addr  <= {pc_q[31:2], 2'b00};
        mem_wdata <= '0;
        mem_wstrb <= 4'h0;
        cnt       <= '0;
      end else if (done | expire) begin
        mem_valid <= 1'b0;
      end else if (mem_valid) begin
        cnt <= cnt + 16'd1;
      end
      if (done && state == DATA && pend_rd) begin
        mdr_load <= 1'b1;
        mdr_data <= mem_rdata;
      end
      if (done && state == FETCH) begin
        mbr_load <= 1'b1;
        mbr_data <= mem_rdata[{pc_q[1:0], 3'b000} +: 8];
      end
    end
  end
endmodule

// File: tb/tb_mic1_mem_ctrl.sv
// tb_mic1_mem_ctrl: scoreboard bench for mic1_mem_ctrl with a wait-state memory responder
module tb_mic1_mem_ctrl;
  logic clk = 0, resetn = 0;
  logic cmd_valid = 0, cmd_wr = 0, cmd_rd = 0, cmd_fetch = 0, cmd_ready;
  logic [31:0] mar = 0, mdr_in = 0, pc = 0;
  logic mdr_load, mbr_load, mem_valid, mem_ready = 0, busy, bus_err, cmd_err;
  logic [31:0] mdr_data, mem_addr, mem_wdata, mem_rdata = 0;
  logic [7:0] mbr_data;
  logic [3:0] mem_wstrb;
  mic1_mem_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_wr(cmd_wr), .cmd_rd(cmd_rd),
    .cmd_fetch(cmd_fetch), .cmd_ready(cmd_ready), .mar(mar), .mdr_in(mdr_in), .pc(pc),
    .mdr_load(mdr_load), .mdr_data(mdr_data), .mbr_load(mbr_load), .mbr_data(mbr_data),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy), .bus_err(bus_err), .cmd_err(cmd_err)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; int len;} bus_t;
  typedef struct {logic [31:0] d; int c;} ld_t;
  bus_t bus_q[$];
  ld_t mdr_q[$], mbr_q[$];
  int cerr_q[$], berr_q[$];
  int checks = 0, failures = 0, cyc = 0;
  int mem_wait = 0, wcnt = 0;
  logic [31:0] rdata_v = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  // memory responder: mem_ready after mem_wait cycles of mem_valid
  always @(negedge clk) begin
    if (mem_valid && !mem_ready) begin
      if (wcnt == mem_wait) begin
        mem_ready = 1;
        mem_rdata = rdata_v;
      end else wcnt++;
    end else begin
      mem_ready = 0;
      wcnt = 0;
    end
  end
  // monitor
  bus_t cur;
  ld_t l;
  logic pv = 0;
  int vlen = 0;
  always @(negedge clk) begin
    if (mem_valid && !pv) begin
      if (bus_q.size() == 0) chk("bus_unexpected", {31'b0, mem_valid}, 0);
      else begin
        cur = bus_q.pop_front();
        chk("bus_addr", mem_addr, cur.addr);
        chk("bus_wdata", mem_wdata, cur.wdata);
        chk("bus_wstrb", {28'b0, mem_wstrb}, {28'b0, cur.wstrb});
      end
      vlen = 1;
    end else if (mem_valid) begin
      vlen++;
      chk("bus_hold", {mem_addr ^ cur.addr, mem_wdata ^ cur.wdata}, 0);
    end
    if (!mem_valid && pv) chk("bus_len", vlen, cur.len);
    pv = mem_valid;
    if (mdr_load) begin
      if (mdr_q.size() == 0) chk("mdr_unexpected", {31'b0, mdr_load}, 0);
      else begin
        l = mdr_q.pop_front();
        chk("mdr_data", mdr_data, l.d);
        chk("mdr_cycle", cyc, l.c);
      end
    end
    if (mbr_load) begin
      if (mbr_q.size() == 0) chk("mbr_unexpected", {31'b0, mbr_load}, 0);
      else begin
        l = mbr_q.pop_front();
        chk("mbr_data", {24'b0, mbr_data}, l.d);
        chk("mbr_cycle", cyc, l.c);
      end
    end
    if (cmd_err) begin
      if (cerr_q.size() == 0) chk("cmd_err_unexpected", {31'b0, cmd_err}, 0);
      else chk("cmd_err_cycle", cyc, cerr_q.pop_front());
    end
    if (bus_err) begin
      if (berr_q.size() == 0) chk("bus_err_unexpected", {31'b0, bus_err}, 0);
      else chk("bus_err_cycle", cyc, berr_q.pop_front());
    end
  end
  task automatic wait_ready(output int t);
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    chk("wait_ready", {31'b0, cmd_ready}, 1);
    t = cyc;
  endtask
  task automatic send(input logic w, input logic r, input logic f, input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
    cmd_valid = 1; cmd_wr = w; cmd_rd = r; cmd_fetch = f; mar = a; mdr_in = d; pc = p;
    @(negedge clk);
    cmd_valid = 0; cmd_wr = 0; cmd_rd = 0; cmd_fetch = 0; mar = 0; mdr_in = 0; pc = 0;
  endtask
  task automatic settle();
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    chk("settle_idle", {31'b0, busy}, 0);
    repeat (2) @(negedge clk);
  endtask
  int t;
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, cmd_ready}, 1);
    chk("rst_bus", {27'b0, mem_valid, mem_wstrb}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_flags", {27'b0, mdr_load, mbr_load, bus_err, cmd_err, busy}, 0);
    chk("rst_mdr", mdr_data, 0);
    chk("rst_mbr", {24'b0, mbr_data}, 0);
    resetn = 1;
    @(negedge clk);
    // READ zero wait
    rdata_v = 32'hDEADBEEF; mem_wait = 0;
    wait_ready(t);
    bus_q.push_back('{32'h40, 32'h0, 4'h0, 1});
    mdr_q.push_back('{32'hDEADBEEF, t + 2});
    send(0, 1, 0, 32'h10, 0, 0);
    chk("read_ready_t1", {31'b0, cmd_ready}, 0);
    @(negedge clk);
    chk("read_ready_t2", {31'b0, cmd_ready}, 1);
    settle();
    // WRITE with 3 wait states (ready on the last counted cycle)
    rdata_v = 0; mem_wait = 3;
    wait_ready(t);
    bus_q.push_back('{32'hC, 32'h12345678, 4'hF, 4});
    send(1, 0, 0, 32'h3, 32'h12345678, 0);
    settle();
    chk("write_busy", {31'b0, busy}, 0);
    // READ+FETCH zero wait
    rdata_v = 32'hA1B2C3D4; mem_wait = 0;
    wait_ready(t);
    bus_q.push_back('{32'h4, 32'h0, 4'h0, 1});
    bus_q.push_back('{32'h4, 32'h0, 4'h0, 1});
    mdr_q.push_back('{32'hA1B2C3D4, t + 2});
    mbr_q.push_back('{32'hA1, t + 4});
    send(0, 1, 1, 32'h1, 0, 32'h7);
    settle();
    // illegal wr+rd with fetch: only the fetch runs
    rdata_v = 32'h11223344;
    wait_ready(t);
    cerr_q.push_back(t + 1);
    bus_q.push_back('{32'h100, 32'h0, 4'h0, 1});
    mbr_q.push_back('{32'h22, t + 2});
    send(1, 1, 1, 32'h5, 32'hCAFE, 32'h102);
    settle();
    // illegal wr+rd alone: nothing issued
    wait_ready(t);
    cerr_q.push_back(t + 1);
    send(1, 1, 0, 32'h9, 32'h1, 0);
    chk("illegal_busy", {31'b0, busy}, 0);
    settle();
    // empty command
    wait_ready(t);
    send(0, 0, 0, 32'h9, 0, 0);
    chk("empty_busy", {31'b0, busy}, 0);
    settle();
    // address wrap, one wait state
    rdata_v = 32'h0BADF00D; mem_wait = 1;
    wait_ready(t);
    bus_q.push_back('{32'h4, 32'h0, 4'h0, 2});
    mdr_q.push_back('{32'h0BADF00D, t + 3});
    send(0, 1, 0, 32'hC0000001, 0, 0);
    settle();
    // timeout: read+fetch, memory never answers
    mem_wait = 1000;
    wait_ready(t);
    bus_q.push_back('{32'h20, 32'h0, 4'h0, 4});
    berr_q.push_back(t + 5);
    send(0, 1, 1, 32'h8, 0, 32'h40);
    settle();
    chk("timeout_busy", {31'b0, busy}, 0);
    // reset during the data wait
    wait_ready(t);
    bus_q.push_back('{32'h8, 32'h0, 4'h0, 2});
    send(0, 1, 0, 32'h2, 0, 0);
    @(negedge clk);
    resetn = 0;
    @(negedge clk);
    chk("rst_mid_valid", {31'b0, mem_valid}, 0);
    chk("rst_mid_busy", {31'b0, busy}, 0);
    resetn = 1; mem_wait = 0; rdata_v = 32'h55AA55AA;
    @(negedge clk);
    wait_ready(t);
    bus_q.push_back('{32'h1C, 32'h0, 4'h0, 1});
    mdr_q.push_back('{32'h55AA55AA, t + 2});
    send(0, 1, 0, 32'h7, 0, 0);
    settle();
    repeat (3) @(negedge clk);
    chk("left_bus", bus_q.size(), 0);
    chk("left_mdr", mdr_q.size(), 0);
    chk("left_mbr", mbr_q.size(), 0);
    chk("left_err", cerr_q.size() + berr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
